// File: rtl/gps_lut_pkg.sv
// gps_lut_pkg: shared types and table geometry for the GPS LUT bracket search controllers
package gps_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SCAN,
        ST_RESP
    } state_t;

    localparam int COS_ADDR_W  = 7;
    localparam int COS_DEPTH   = 128;
    localparam int COS_KEY_W   = 48;
    localparam int COS_VAL_W   = 48;

    localparam int ASIN_ADDR_W = 6;
    localparam int ASIN_DEPTH  = 64;
    localparam int ASIN_KEY_W  = 64;
    localparam int ASIN_VAL_W  = 64;

endpackage

// File: rtl/gps_rr_arb2.sv
// gps_rr_arb2: two-way round-robin arbiter with one-hot grant
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-high reset (requester 0 gets priority)
//   i_en     grants allowed this cycle
//   i_req    request vector {req1, req0}
//   o_grant  one-hot grant, zero when disabled or idle
module gps_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    // r_prio set means requester 1 wins a tie
    logic r_prio;

    always_comb
        o_grant = !i_en ? 2'b00 : (i_req == 2'b11) ? (r_prio ? 2'b10 : 2'b01) : i_req;

    // Pointer moves only on an actual grant, towards the requester not just served
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset)
            r_prio <= 1'b0;
        else if (|o_grant)
            r_prio <= o_grant[0];

endmodule

// File: rtl/gps_lut_bracket_ctrl.sv
// gps_lut_bracket_ctrl: arbitrated linear search of a monotonic LUT returning bracketing entries
// Ports:
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_reqN_valid/i_reqN_key      requester N key (N = 0, 1)
//   o_reqN_ready                 key N accepted this cycle (IDLE only, at most one)
//   o_rom_addr / i_rom_data      synchronous ROM port, data {x,y} one cycle after address
//   o_rsp_valid / i_rsp_ready    bracket result handshake
//   o_rsp_id, o_rsp_idx          requester served, index of lower entry
//   o_rsp_x0/y0, o_rsp_x1/y1     lower and upper entries
//   o_rsp_exact, o_rsp_clamp     key equals an x / key outside the table
//   o_busy                       controller not idle
// Optional feature: define GPS_LUT_HINT_EN to start each search at the previous lower index
// when the new key is not below that entry's x.
module gps_lut_bracket_ctrl
    import gps_lut_pkg::*;
#(
    parameter int ADDR_W = COS_ADDR_W,
    parameter int DEPTH  = COS_DEPTH,
    parameter int KEY_W  = COS_KEY_W,
    parameter int VAL_W  = COS_VAL_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req0_valid,
    input  logic [KEY_W-1:0]       i_req0_key,
    output logic                   o_req0_ready,
    input  logic                   i_req1_valid,
    input  logic [KEY_W-1:0]       i_req1_key,
    output logic                   o_req1_ready,
    output logic [ADDR_W-1:0]      o_rom_addr,
    input  logic [KEY_W+VAL_W-1:0] i_rom_data,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic                   o_rsp_id,
    output logic [ADDR_W-1:0]      o_rsp_idx,
    output logic [KEY_W-1:0]       o_rsp_x0,
    output logic [VAL_W-1:0]       o_rsp_y0,
    output logic [KEY_W-1:0]       o_rsp_x1,
    output logic [VAL_W-1:0]       o_rsp_y1,
    output logic                   o_rsp_exact,
    output logic                   o_rsp_clamp,
    output logic                   o_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_next;
    logic              w_idle;
    logic [1:0]        w_grant;
    logic [KEY_W-1:0]  w_key_sel, w_x, r_key, r_px;
    logic [VAL_W-1:0]  w_y, r_py;
    logic [ADDR_W-1:0] r_idx, w_start, w_next_addr, w_res_idx;
    logic              w_hit, w_last, w_exact, w_both, w_done;

    gps_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_idle),
        .i_req   ({i_req1_valid, i_req0_valid}),
        .o_grant (w_grant)
    );

    assign o_req0_ready = w_grant[0];
    assign o_req1_ready = w_grant[1];
    assign w_key_sel    = w_grant[1] ? i_req1_key : i_req0_key;

    // r_idx is the index whose entry is on i_rom_data during SCAN
    assign w_x         = i_rom_data[KEY_W+VAL_W-1:VAL_W];
    assign w_y         = i_rom_data[VAL_W-1:0];
    assign w_hit       = w_x >= r_key;
    assign w_exact     = w_x == r_key;
    assign w_last      = r_idx == LAST;
    assign w_done      = (r_state == ST_SCAN) && (w_hit || w_last);
    // Exact match, below-range (hit at 0) and above-range (no hit) return a single entry
    assign w_both      = w_exact || !w_hit || r_idx == '0;
    assign w_res_idx   = w_both ? r_idx : r_idx - 1'b1;
    assign w_next_addr = (o_rom_addr == LAST) ? LAST : o_rom_addr + 1'b1;

`ifdef GPS_LUT_HINT_EN
    logic [ADDR_W-1:0] r_hint_idx;
    logic [KEY_W-1:0]  r_hint_x;

    assign w_start = (w_key_sel >= r_hint_x) ? r_hint_idx : '0;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_hint_idx <= '0;
            r_hint_x   <= '0;
        end else if (w_done) begin
            r_hint_idx <= w_res_idx;
            r_hint_x   <= w_both ? w_x : r_px;
        end
`else
    assign w_start = '0;
`endif

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = |w_grant ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_next = ST_SCAN;
            ST_SCAN:  w_next = w_done ? ST_RESP : ST_SCAN;
            ST_RESP:  w_next = i_rsp_ready ? ST_IDLE : ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle      = r_state == ST_IDLE;
        o_busy      = !w_idle;
        o_rsp_valid = r_state == ST_RESP;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_key       <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_idx       <= '0;
            o_rom_addr  <= '0;
            o_rsp_id    <= 1'b0;
            o_rsp_idx   <= '0;
            o_rsp_x0    <= '0;
            o_rsp_y0    <= '0;
            o_rsp_x1    <= '0;
            o_rsp_y1    <= '0;
            o_rsp_exact <= 1'b0;
            o_rsp_clamp <= 1'b0;
        end else begin
            if (w_idle && |w_grant) begin
                r_key      <= w_key_sel;
                o_rsp_id   <= w_grant[1];
                o_rom_addr <= w_start;
            end
            // Pipeline: the address issued in cycle n is compared in cycle n+1
            if (r_state == ST_ISSUE) begin
                r_idx      <= o_rom_addr;
                o_rom_addr <= w_next_addr;
            end
            if (r_state == ST_SCAN && !w_done) begin
                r_idx      <= r_idx + 1'b1;
                r_px       <= w_x;
                r_py       <= w_y;
                o_rom_addr <= w_next_addr;
            end
            if (w_done) begin
                o_rsp_idx   <= w_res_idx;
                o_rsp_x0    <= w_both ? w_x : r_px;
                o_rsp_y0    <= w_both ? w_y : r_py;
                o_rsp_x1    <= w_x;
                o_rsp_y1    <= w_y;
                o_rsp_exact <= w_exact;
                o_rsp_clamp <= w_both && !w_exact;
            end
        end
    end

endmodule

// File: tb/tb_gps_lut_bracket_ctrl.sv
// tb_gps_lut_bracket_ctrl: directed bench, 8-entry table x[i]=5+10i, y[i]=100+i
module tb_gps_lut_bracket_ctrl;

    localparam int AW = 4;
    localparam int DP = 8;
    localparam int KW = 16;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [KW-1:0] req0_key = '0, req1_key = '0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] rom_addr;
    logic [KW+VW-1:0] rom_data = '0;
    logic          rsp_valid, rsp_id, rsp_exact, rsp_clamp, busy;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] rsp_idx;
    logic [KW-1:0] rsp_x0, rsp_x1;
    logic [VW-1:0] rsp_y0, rsp_y1;

    int tests  = 0;
    int failed = 0;

    gps_lut_bracket_ctrl #(.ADDR_W(AW), .DEPTH(DP), .KEY_W(KW), .VAL_W(VW)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req0_valid (req0_valid),
        .i_req0_key   (req0_key),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_key   (req1_key),
        .o_req1_ready (req1_ready),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_idx    (rsp_idx),
        .o_rsp_x0     (rsp_x0),
        .o_rsp_y0     (rsp_y0),
        .o_rsp_x1     (rsp_x1),
        .o_rsp_y1     (rsp_y1),
        .o_rsp_exact  (rsp_exact),
        .o_rsp_clamp  (rsp_clamp),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM; out-of-range addresses return all ones
    always @(posedge clk)
        rom_data <= (rom_addr < AW'(DP)) ? {KW'(5 + 10 * int'(rom_addr)), VW'(100 + int'(rom_addr))} : '1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request; lat counts cycles after the grant cycle until rsp_valid
    task automatic run_req(input logic id, input logic [KW-1:0] key, output int lat,
                           output logic [AW-1:0] first_addr, output logic [AW-1:0] max_addr);
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_key = key; end
        else    begin req0_valid = 1'b1; req0_key = key; end
        #1;
        tests++;
        if ((id ? req1_ready : req0_ready) !== 1'b1) begin
            failed++;
            $display("FAIL grant key %0d: ready=%b required 1", key, id ? req1_ready : req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        first_addr = rom_addr;
        max_addr   = rom_addr;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rom_addr > max_addr) max_addr = rom_addr;
        end
    endtask

    task automatic test_search(input string tag, input bit fresh, input logic id, input logic [KW-1:0] key,
                               input logic [AW-1:0] e_start, input logic [AW-1:0] e_idx,
                               input logic [KW-1:0] e_x0, input logic [VW-1:0] e_y0,
                               input logic [KW-1:0] e_x1, input logic [VW-1:0] e_y1,
                               input logic e_ex, input logic e_cl, input int e_lat,
                               output logic [AW-1:0] max_addr);
        int lat;
        logic [AW-1:0] fa;
        if (fresh) do_reset();
        run_req(id, key, lat, fa, max_addr);
        tests++;
        if (lat != e_lat) begin
            failed++;
            $display("FAIL %s latency: got T+%0d required T+%0d", tag, lat, e_lat);
        end
        tests++;
        if (fa !== e_start) begin
            failed++;
            $display("FAIL %s start addr: got %0d required %0d", tag, fa, e_start);
        end
        tests++;
        if ({rsp_id, rsp_idx, rsp_exact, rsp_clamp} !== {id, e_idx, e_ex, e_cl}) begin
            failed++;
            $display("FAIL %s id/idx/exact/clamp: got %b/%0d/%b/%b required %b/%0d/%b/%b", tag,
                     rsp_id, rsp_idx, rsp_exact, rsp_clamp, id, e_idx, e_ex, e_cl);
        end
        tests++;
        if ({rsp_x0, rsp_y0, rsp_x1, rsp_y1} !== {e_x0, e_y0, e_x1, e_y1}) begin
            failed++;
            $display("FAIL %s entries: got (%0d,%0d)(%0d,%0d) required (%0d,%0d)(%0d,%0d)", tag,
                     rsp_x0, rsp_y0, rsp_x1, rsp_y1, e_x0, e_y0, e_x1, e_y1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rom_addr, rsp_id, rsp_idx, rsp_x0, rsp_y0,
             rsp_x1, rsp_y1, rsp_exact, rsp_clamp} !== '0) begin
            failed++;
            $display("FAIL reset outputs: valid=%b busy=%b addr=%0d idx=%0d x0=%0d not all 0",
                     rsp_valid, busy, rom_addr, rsp_idx, rsp_x0);
        end
        rst = 1'b0;
    endtask

    task automatic test_bracket();
        logic [AW-1:0] ma;
        test_search("bracket30", 1, 0, 30, 0, 2, 25, 102, 35, 103, 0, 0, 6, ma);
        test_search("bracket36", 1, 0, 36, 0, 3, 35, 103, 45, 104, 0, 0, 7, ma);
    endtask

    task automatic test_exact();
        logic [AW-1:0] ma;
        test_search("exact25", 1, 1, 25, 0, 2, 25, 102, 25, 102, 1, 0, 5, ma);
    endtask

    task automatic test_clamp();
        logic [AW-1:0] ma;
        test_search("clamp_lo", 1, 0, 2, 0, 0, 5, 100, 5, 100, 0, 1, 3, ma);
        test_search("clamp_hi", 0, 0, 80, 0, 7, 75, 107, 75, 107, 0, 1, 10, ma);
        tests++;
        if (ma !== 4'd7) begin
            failed++;
            $display("FAIL clamp_hi max rom_addr: got %0d required 7", ma);
        end
    endtask

    task automatic test_start_index();
        logic [AW-1:0] ma;
`ifdef GPS_LUT_HINT_EN
        test_search("start_first", 1, 0, 30, 0, 2, 25, 102, 35, 103, 0, 0, 6, ma);
        test_search("start_resume", 0, 0, 50, 2, 4, 45, 104, 55, 105, 0, 0, 6, ma);
        test_search("start_low", 0, 0, 10, 0, 0, 5, 100, 15, 101, 0, 0, 4, ma);
`else
        test_search("start_first", 1, 0, 30, 0, 2, 25, 102, 35, 103, 0, 0, 6, ma);
        test_search("start_zero", 0, 0, 50, 0, 4, 45, 104, 55, 105, 0, 0, 8, ma);
`endif
    endtask

    task automatic test_arbitration();
        logic [2:0] gs = '0;
        int n = 0;
        do_reset();
        req0_key   = 2;
        req1_key   = 2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            #1;
            tests++;
            if (req0_ready && req1_ready) begin
                failed++;
                $display("FAIL arb onehot: ready0=%b ready1=%b required at most one", req0_ready, req1_ready);
            end
            tests++;
            if (busy && (req0_ready || req1_ready)) begin
                failed++;
                $display("FAIL arb ready while busy: ready0=%b ready1=%b required 0", req0_ready, req1_ready);
            end
            if (req0_ready || req1_ready) begin
                gs[n] = req1_ready;
                n++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests++;
        if (n != 3 || gs !== 3'b010) begin
            failed++;
            $display("FAIL arb order: got %0d grants pattern %b required 3 grants 0,1,0 (010)", n, gs);
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    endtask

    task automatic test_hold_and_reset();
        int lat;
        logic [AW-1:0] fa, ma;
        rsp_ready = 1'b0;
        run_req(0, 30, lat, fa, ma);
        tests++;
        if (lat != 6) begin
            failed++;
            $display("FAIL hold latency: got T+%0d required T+6", lat);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (!rsp_valid || {rsp_idx, rsp_x0, rsp_y0, rsp_x1, rsp_y1} !==
                {4'd2, 16'd25, 16'd102, 16'd35, 16'd103}) begin
                failed++;
                $display("FAIL hold cycle %0d: valid=%b idx=%0d (%0d,%0d)(%0d,%0d) required 1 2 (25,102)(35,103)",
                         i, rsp_valid, rsp_idx, rsp_x0, rsp_y0, rsp_x1, rsp_y1);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL hold release: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        req0_valid = 1'b1;
        req0_key   = 80;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL midscan busy: got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({rsp_valid, busy, rom_addr} !== '0) begin
            failed++;
            $display("FAIL midscan reset: valid=%b busy=%b addr=%0d required 0 0 0", rsp_valid, busy, rom_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        test_search("after_reset", 0, 0, 30, 0, 2, 25, 102, 35, 103, 0, 0, 6, ma);
    endtask

    initial begin
        test_reset();
        test_bracket();
        test_exact();
        test_clamp();
        test_start_index();
        test_arbitration();
        test_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
